// File: rtl/psp_trace_recorder.sv
// psp_trace_recorder: decimated circular history of the PSP trace plus threshold spike detect/count.
// Define PSP_PEAK_HOLD_EN to store the per-window peak instead of the tick-cycle sample.
module psp_trace_recorder #(
    parameter int c_THRESHOLD = 500,
    parameter int c_DEPTH     = 64,
    parameter int c_DECIMATE  = 1024
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic [9:0]                 i_PSP_Trace,
    input  logic                       i_Freeze,
    input  logic [$clog2(c_DEPTH)-1:0] i_Rd_Addr,
    output logic [9:0]                 o_Rd_Data,
    output logic                       o_Sample_Valid,
    output logic                       o_Spike,
    output logic [15:0]                o_Spike_Count,
    output logic                       o_Full
);
    localparam int AW = $clog2(c_DEPTH);
    localparam int CW = $clog2(c_DECIMATE);

    logic [9:0]    mem [c_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_phys;
    logic [AW:0]   fill;
    logic [CW-1:0] dec_cnt;
    logic [9:0]    prev;
    logic [9:0]    sample;
    logic          tick;
    logic          crossing;

    assign o_Full   = fill == (AW+1)'(c_DEPTH);
    assign tick     = dec_cnt == CW'(c_DECIMATE - 1) && !i_Freeze;
    assign crossing = prev < 10'(c_THRESHOLD) && i_PSP_Trace >= 10'(c_THRESHOLD);
    // Once full, the write pointer sits on the oldest entry.
    assign rd_phys  = o_Full ? wr_ptr + i_Rd_Addr : i_Rd_Addr;

`ifdef PSP_PEAK_HOLD_EN
    logic [9:0] peak;
    assign sample = i_PSP_Trace > peak ? i_PSP_Trace : peak;
    always_ff @(posedge i_Clk) peak <= (i_Reset || tick) ? '0 : sample;
`else
    assign sample = i_PSP_Trace;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            wr_ptr         <= '0;
            fill           <= '0;
            dec_cnt        <= '0;
            prev           <= '0;
            o_Rd_Data      <= '0;
            o_Sample_Valid <= 1'b0;
            o_Spike        <= 1'b0;
            o_Spike_Count  <= '0;
        end else begin
            dec_cnt <= tick ? '0 : i_Freeze ? dec_cnt : dec_cnt + 1'b1;
            if (tick) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!o_Full) fill <= fill + 1'b1;
            end
            prev           <= i_PSP_Trace;
            o_Rd_Data      <= (!o_Full && {1'b0, i_Rd_Addr} >= fill) ? '0 : mem[rd_phys];
            o_Sample_Valid <= tick;
            o_Spike        <= crossing;
            if (crossing && o_Spike_Count != 16'hFFFF) o_Spike_Count <= o_Spike_Count + 1'b1;
        end
    end

    // Memory has no reset; the fill count masks stale contents.
    always_ff @(posedge i_Clk) begin
        if (tick && !i_Reset) mem[wr_ptr] <= sample;
    end
endmodule

// File: tb/tb_psp_trace_recorder.sv
// tb_psp_trace_recorder: directed and randomized checks of psp_trace_recorder against a queue-based history model.
module tb_psp_trace_recorder;
    localparam int TH = 500, DEPTH = 8, DEC = 4;

    logic        clk = 1'b0, rst = 1'b1, freeze = 1'b0, preload = 1'b0;
    logic [9:0]  trace = '0;
    logic [2:0]  addr = '0;
    logic [9:0]  rd;
    logic        valid, spike, full;
    logic [15:0] cnt;
    int tests = 0, fails = 0;

    logic [9:0] hist[$];
    int win, wmax, prev_m, m_cnt;
    logic [9:0] e_rd;
    logic e_valid, e_spike;

    psp_trace_recorder #(.c_THRESHOLD(TH), .c_DEPTH(DEPTH), .c_DECIMATE(DEC)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_PSP_Trace(trace), .i_Freeze(freeze), .i_Rd_Addr(addr),
        .o_Rd_Data(rd), .o_Sample_Valid(valid), .o_Spike(spike), .o_Spike_Count(cnt), .o_Full(full)
    );

    always #5 clk = ~clk;

    // Reference: history as an oldest-first queue, window counted in cycles.
    always @(posedge clk) begin
        int samp;
        if (rst) begin
            hist.delete();
            win = 0; wmax = 0; prev_m = 0; m_cnt = 0;
            e_rd = '0; e_valid = 1'b0; e_spike = 1'b0;
        end else begin
            if (preload) m_cnt = 65534;
            e_rd = int'(addr) < hist.size() ? hist[addr] : 10'd0;
            e_spike = prev_m < TH && int'(trace) >= TH;
            if (e_spike && m_cnt < 65535) m_cnt++;
            prev_m = int'(trace);
`ifdef PSP_PEAK_HOLD_EN
            samp = int'(trace) > wmax ? int'(trace) : wmax;
`else
            samp = int'(trace);
`endif
            wmax = int'(trace) > wmax ? int'(trace) : wmax;
            e_valid = !freeze && win == DEC - 1;
            if (e_valid) begin
                hist.push_back(10'(samp));
                if (hist.size() > DEPTH) void'(hist.pop_front());
                win = 0;
                wmax = 0;
            end else if (!freeze) win++;
        end
    end

    task automatic apply_reset();
        rst = 1'b1; freeze = 1'b0; addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; trace = 10'd700; freeze = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (rd !== 10'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", rd); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        tests++; if (spike !== 1'b0) begin fails++; $display("FAIL reset_spike got %b want 0", spike); end
        tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", cnt); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        rst = 1'b0;
    endtask

    task automatic test_constant();
        trace = 10'd100;
        apply_reset();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            tests++; if (valid !== (k % 4 == 0)) begin fails++; $display("FAIL const_valid cyc %0d got %b want %b", k, valid, k % 4 == 0); end
            tests++; if (full !== (k >= 32)) begin fails++; $display("FAIL const_full cyc %0d got %b want %b", k, full, k >= 32); end
        end
        freeze = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            addr = 3'(a);
            @(negedge clk);
            tests++; if (rd !== 10'd100) begin fails++; $display("FAIL const_read addr %0d got %0d want 100", a, rd); end
        end
        freeze = 1'b0;
    endtask

    task automatic test_ramp();
        trace = 10'd0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            trace = 10'(10 * k);
            repeat (4) @(negedge clk);
        end
        freeze = 1'b1;
        addr = 3'd0;
        @(negedge clk);
        tests++; if (rd !== 10'd20) begin fails++; $display("FAIL ramp_oldest got %0d want 20", rd); end
        addr = 3'd7;
        @(negedge clk);
        tests++; if (rd !== 10'd90) begin fails++; $display("FAIL ramp_newest got %0d want 90", rd); end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ramp_full got %b want 1", full); end
        freeze = 1'b0;
    endtask

    task automatic test_spike();
        logic [9:0] seq [5] = '{10'd499, 10'd500, 10'd500, 10'd450, 10'd500};
        logic       want [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int pulses = 0;
        trace = 10'd0;
        apply_reset();
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trace = seq[i];
            @(negedge clk);
            pulses += int'(spike);
            tests++; if (spike !== want[i]) begin fails++; $display("FAIL spike_step %0d got %b want %b", i, spike, want[i]); end
        end
        tests++; if (pulses != 2) begin fails++; $display("FAIL spike_pulses got %0d want 2", pulses); end
        tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL spike_count got %0d want 2", cnt); end
        freeze = 1'b0;
    endtask

    task automatic test_peak();
        logic [9:0] want;
`ifdef PSP_PEAK_HOLD_EN
        want = 10'd500;
`else
        want = 10'd100;
`endif
        trace = 10'd100;
        apply_reset();
        @(negedge clk);
        trace = 10'd500;
        @(negedge clk);
        trace = 10'd100;
        repeat (2) @(negedge clk);
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL peak_valid got %b want 1", valid); end
        freeze = 1'b1;
        addr = 3'd0;
        @(negedge clk);
        tests++; if (rd !== want) begin fails++; $display("FAIL peak_sample got %0d want %0d", rd, want); end
        tests++; if (cnt !== 16'd1) begin fails++; $display("FAIL peak_count got %0d want 1", cnt); end
        freeze = 1'b0;
    endtask

    task automatic test_freeze();
        trace = 10'd100;
        apply_reset();
        repeat (7) @(negedge clk);
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            trace = (i % 2) ? 10'd600 : 10'd100;
            @(negedge clk);
            tests++; if (valid !== 1'b0) begin fails++; $display("FAIL freeze_valid cyc %0d got %b want 0", i, valid); end
        end
        freeze = 1'b0;
        trace = 10'd100;
        @(negedge clk);
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL freeze_resume got %b want 1", valid); end
        tests++; if (cnt !== 16'd5) begin fails++; $display("FAIL freeze_spikes got %0d want 5", cnt); end
        freeze = 1'b1;
        addr = 3'd2;
        @(negedge clk);
        tests++; if (rd !== 10'd0) begin fails++; $display("FAIL freeze_wrptr got %0d want 0", rd); end
        addr = 3'd1;
        @(negedge clk);
        tests++; if (rd !== 10'd100) begin fails++; $display("FAIL freeze_second got %0d want 100", rd); end
        freeze = 1'b0;
    endtask

    task automatic test_random();
        trace = 10'd0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            tests++; if (rd !== e_rd) begin fails++; $display("FAIL rand_rd cyc %0d got %0d want %0d", i, rd, e_rd); end
            tests++; if (valid !== e_valid) begin fails++; $display("FAIL rand_valid cyc %0d got %b want %b", i, valid, e_valid); end
            tests++; if (spike !== e_spike) begin fails++; $display("FAIL rand_spike cyc %0d got %b want %b", i, spike, e_spike); end
            tests++; if (cnt !== 16'(m_cnt)) begin fails++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, cnt, m_cnt); end
            tests++; if (full !== (hist.size() == DEPTH)) begin fails++; $display("FAIL rand_full cyc %0d got %b want %b", i, full, hist.size() == DEPTH); end
            trace  = $urandom_range(0, 1) ? 10'($urandom_range(480, 520)) : 10'($urandom_range(0, 1023));
            freeze = $urandom_range(0, 7) == 0;
            addr   = 3'($urandom);
            rst    = $urandom_range(0, 199) == 0;
        end
        rst = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        trace = 10'd100;
        apply_reset();
        repeat (5) @(negedge clk);
        trace = 10'd600;
        @(negedge clk);
        trace = 10'd100;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({rd, valid, spike, cnt, full} !== '0) begin fails++; $display("FAIL mid_reset rd %0d v %b s %b c %0d f %b want all 0", rd, valid, spike, cnt, full); end
        rst = 1'b0;
        freeze = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            addr = 3'(a);
            @(negedge clk);
            tests++; if (rd !== 10'd0) begin fails++; $display("FAIL mid_read addr %0d got %0d want 0", a, rd); end
        end
        preload = 1'b1;
        force dut.o_Spike_Count = 16'hFFFE;
        @(negedge clk);
        release dut.o_Spike_Count;
        preload = 1'b0;
        for (int i = 0; i < 2; i++) begin
            trace = 10'd600;
            @(negedge clk);
            tests++; if (spike !== 1'b1) begin fails++; $display("FAIL sat_spike %0d got %b want 1", i, spike); end
            tests++; if (cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_count %0d got %h want ffff", i, cnt); end
            trace = 10'd100;
            @(negedge clk);
        end
        freeze = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_spike();
        test_peak();
        test_freeze();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
